// File: rtl/dcache_port_arbiter.sv
// dcache_port_arbiter
// Shares the single dcache request port between the mem stage (requester 0) and the
// aux engine (requester 1, store-buffer drain / cacop). Only one transaction is in
// flight at a time, and each response goes back to the requester that issued it.
// Mem has priority. A starvation counter forces an aux grant after STARVE_LIMIT
// consecutive mem grants that each blocked a waiting aux request. Flush squashes
// the response of a mem-owned transaction without aborting it at the dcache.
//
// Ports
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   flush_i                   pipeline flush
//   mem_req_* / mem_resp_*    requester 0 request handshake and response pulse
//   aux_req_* / aux_resp_*    requester 1 request handshake and response pulse
//   dc_req_* / dc_*           registered request to the dcache
//   dc_resp_valid_i/rdata_i   dcache response, one per accepted request
//   busy_o                    arbiter is not idle
`timescale 1ns / 1ps
module dcache_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    flush_i,
  input  logic                    mem_req_valid_i,
  output logic                    mem_req_ready_o,
  input  logic                    mem_req_we_i,
  input  logic [ADDR_WIDTH-1:0]   mem_req_addr_i,
  input  logic [DATA_WIDTH-1:0]   mem_req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] mem_req_wstrb_i,
  output logic                    mem_resp_valid_o,
  output logic [DATA_WIDTH-1:0]   mem_resp_rdata_o,
  input  logic                    aux_req_valid_i,
  output logic                    aux_req_ready_o,
  input  logic                    aux_req_we_i,
  input  logic [ADDR_WIDTH-1:0]   aux_req_addr_i,
  input  logic [DATA_WIDTH-1:0]   aux_req_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] aux_req_wstrb_i,
  output logic                    aux_resp_valid_o,
  output logic [DATA_WIDTH-1:0]   aux_resp_rdata_o,
  output logic                    dc_req_valid_o,
  input  logic                    dc_req_ready_i,
  output logic                    dc_we_o,
  output logic [ADDR_WIDTH-1:0]   dc_addr_o,
  output logic [DATA_WIDTH-1:0]   dc_wdata_o,
  output logic [DATA_WIDTH/8-1:0] dc_wstrb_o,
  input  logic                    dc_resp_valid_i,
  input  logic [DATA_WIDTH-1:0]   dc_resp_rdata_i,
  output logic                    busy_o
);

  localparam int unsigned SW   = DATA_WIDTH / 8;
  localparam int unsigned CntW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(STARVE_LIMIT);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

  state_e                state_q, state_d;
  logic                  owner_q, owner_d;  // 0 = mem, 1 = aux
  logic                  drop_q, drop_d;
  logic [CntW-1:0]       starve_q, starve_d;
  logic                  dc_we_q, dc_we_d;
  logic [ADDR_WIDTH-1:0] dc_addr_q, dc_addr_d;
  logic [DATA_WIDTH-1:0] dc_wdata_q, dc_wdata_d;
  logic [SW-1:0]         dc_wstrb_q, dc_wstrb_d;
  logic                  mem_resp_valid_q, mem_resp_valid_d;
  logic                  aux_resp_valid_q, aux_resp_valid_d;
  logic [DATA_WIDTH-1:0] mem_rdata_q, mem_rdata_d;
  logic [DATA_WIDTH-1:0] aux_rdata_q, aux_rdata_d;

  logic grant_mem, grant_aux;

  // Grant decision; only acted upon in StIdle.
  always_comb begin
    logic prio_aux;
    logic mem_eligible;
    prio_aux     = (starve_q == Limit);
    mem_eligible = mem_req_valid_i && !flush_i;
    grant_aux    = aux_req_valid_i && (prio_aux || !mem_eligible);
    grant_mem    = mem_eligible && !grant_aux;
  end

  always_comb begin
    state_d          = state_q;
    owner_d          = owner_q;
    drop_d           = drop_q;
    starve_d         = starve_q;
    dc_we_d          = dc_we_q;
    dc_addr_d        = dc_addr_q;
    dc_wdata_d       = dc_wdata_q;
    dc_wstrb_d       = dc_wstrb_q;
    mem_rdata_d      = mem_rdata_q;
    aux_rdata_d      = aux_rdata_q;
    mem_resp_valid_d = 1'b0;
    aux_resp_valid_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (grant_aux) begin
          starve_d = '0;
        end else if (grant_mem && aux_req_valid_i && (starve_q != Limit)) begin
          starve_d = starve_q + CntW'(1);
        end
        if (grant_aux || grant_mem) begin
          owner_d    = grant_aux;
          drop_d     = 1'b0;
          dc_we_d    = grant_aux ? aux_req_we_i    : mem_req_we_i;
          dc_addr_d  = grant_aux ? aux_req_addr_i  : mem_req_addr_i;
          dc_wdata_d = grant_aux ? aux_req_wdata_i : mem_req_wdata_i;
          dc_wstrb_d = grant_aux ? aux_req_wstrb_i : mem_req_wstrb_i;
          state_d    = StReq;
        end
      end
      StReq: begin
        if (dc_req_ready_i) state_d = StWait;
      end
      StWait: begin
        if (dc_resp_valid_i) begin
          state_d = StIdle;
          if (owner_q) begin
            aux_rdata_d      = dc_resp_rdata_i;
            aux_resp_valid_d = 1'b1;
          end else begin
            // Data is still captured for a squashed load; only the pulse is suppressed.
            mem_rdata_d      = dc_resp_rdata_i;
            mem_resp_valid_d = !(drop_q || flush_i);
          end
        end
      end
      default: state_d = StIdle;
    endcase

    // The dcache transaction always completes; flush only marks its response as dead.
    if ((state_q != StIdle) && !owner_q && flush_i) drop_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= StIdle;
      owner_q          <= 1'b0;
      drop_q           <= 1'b0;
      starve_q         <= '0;
      dc_we_q          <= 1'b0;
      dc_addr_q        <= '0;
      dc_wdata_q       <= '0;
      dc_wstrb_q       <= '0;
      mem_rdata_q      <= '0;
      aux_rdata_q      <= '0;
      mem_resp_valid_q <= 1'b0;
      aux_resp_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      owner_q          <= owner_d;
      drop_q           <= drop_d;
      starve_q         <= starve_d;
      dc_we_q          <= dc_we_d;
      dc_addr_q        <= dc_addr_d;
      dc_wdata_q       <= dc_wdata_d;
      dc_wstrb_q       <= dc_wstrb_d;
      mem_rdata_q      <= mem_rdata_d;
      aux_rdata_q      <= aux_rdata_d;
      mem_resp_valid_q <= mem_resp_valid_d;
      aux_resp_valid_q <= aux_resp_valid_d;
    end
  end

  assign mem_req_ready_o  = (state_q == StIdle) && grant_mem;
  assign aux_req_ready_o  = (state_q == StIdle) && grant_aux;
  assign dc_req_valid_o   = (state_q == StReq);
  assign dc_we_o          = dc_we_q;
  assign dc_addr_o        = dc_addr_q;
  assign dc_wdata_o       = dc_wdata_q;
  assign dc_wstrb_o       = dc_wstrb_q;
  assign mem_resp_valid_o = mem_resp_valid_q;
  assign mem_resp_rdata_o = mem_rdata_q;
  assign aux_resp_valid_o = aux_resp_valid_q;
  assign aux_resp_rdata_o = aux_rdata_q;
  assign busy_o           = (state_q != StIdle);

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Scoreboard bench for dcache_port_arbiter: directed transactions push expected dcache
// requests and responses into queues; a monitor pops and compares as the DUT presents them.
`timescale 1ns / 1ps
module tb_dcache_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        mem_req_valid = 1'b0, mem_req_ready, mem_req_we = 1'b0;
  logic [31:0] mem_req_addr = '0, mem_req_wdata = '0;
  logic [3:0]  mem_req_wstrb = '0;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_rdata;
  logic        aux_req_valid = 1'b0, aux_req_ready, aux_req_we = 1'b0;
  logic [31:0] aux_req_addr = '0, aux_req_wdata = '0;
  logic [3:0]  aux_req_wstrb = '0;
  logic        aux_resp_valid;
  logic [31:0] aux_resp_rdata;
  logic        dc_req_valid, dc_req_ready = 1'b1, dc_we;
  logic [31:0] dc_addr, dc_wdata;
  logic [3:0]  dc_wstrb;
  logic        dc_resp_valid;
  logic [31:0] dc_resp_rdata;
  logic        busy;

  always #5 clk = ~clk;

  dcache_port_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .STARVE_LIMIT(8)) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .mem_req_valid_i(mem_req_valid), .mem_req_ready_o(mem_req_ready),
    .mem_req_we_i(mem_req_we), .mem_req_addr_i(mem_req_addr),
    .mem_req_wdata_i(mem_req_wdata), .mem_req_wstrb_i(mem_req_wstrb),
    .mem_resp_valid_o(mem_resp_valid), .mem_resp_rdata_o(mem_resp_rdata),
    .aux_req_valid_i(aux_req_valid), .aux_req_ready_o(aux_req_ready),
    .aux_req_we_i(aux_req_we), .aux_req_addr_i(aux_req_addr),
    .aux_req_wdata_i(aux_req_wdata), .aux_req_wstrb_i(aux_req_wstrb),
    .aux_resp_valid_o(aux_resp_valid), .aux_resp_rdata_o(aux_resp_rdata),
    .dc_req_valid_o(dc_req_valid), .dc_req_ready_i(dc_req_ready),
    .dc_we_o(dc_we), .dc_addr_o(dc_addr), .dc_wdata_o(dc_wdata), .dc_wstrb_o(dc_wstrb),
    .dc_resp_valid_i(dc_resp_valid), .dc_resp_rdata_i(dc_resp_rdata),
    .busy_o(busy)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {logic who; logic [31:0] rdata;} resp_t;
  typedef struct packed {logic we; logic [31:0] addr; logic [31:0] wdata; logic [3:0] wstrb;} dreq_t;
  resp_t exp_resp[$];
  dreq_t exp_dc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got event expected none", name);
  endtask

  // Bench dcache contents: two named words, everything else is addr ^ 0x12345678.
  function automatic logic [31:0] dc_data(input logic [31:0] a);
    case (a)
      32'h0000_1000: return 32'hDEAD_BEEF;
      32'h0000_2000: return 32'hCAFE_F00D;
      default:       return a ^ 32'h1234_5678;
    endcase
  endfunction

  // dcache model: answers resp_delay cycles after each accepted request.
  int          resp_delay = 1;
  int          cnt = 0;
  logic        hs_seen = 1'b0;
  logic [31:0] lat_addr = '0;
  logic        model_v = 1'b0;
  logic [31:0] model_rd = '0;
  assign dc_resp_valid = model_v;
  assign dc_resp_rdata = model_rd;

  initial forever begin
    @(negedge clk);
    hs_seen = dc_req_valid && dc_req_ready;
  end

  initial forever begin
    @(posedge clk);
    #1;
    model_v = 1'b0;
    if (hs_seen) begin
      cnt      = resp_delay;
      lat_addr = dc_addr;
    end
    if (cnt > 0) begin
      cnt--;
      if (cnt == 0) begin
        model_v  = 1'b1;
        model_rd = dc_data(lat_addr);
      end
    end
  end

  // Monitor: compares dcache requests and response pulses against the queues.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (dc_req_valid && dc_req_ready) begin
        if (exp_dc.size() == 0) fail_now("dc_req_unexpected");
        else begin
          dreq_t d;
          d = exp_dc.pop_front();
          chk("dc_we", dc_we, d.we);
          chk("dc_addr", dc_addr, d.addr);
          chk("dc_wdata", dc_wdata, d.wdata);
          chk("dc_wstrb", dc_wstrb, d.wstrb);
        end
      end
      if (mem_resp_valid || aux_resp_valid) begin
        if (exp_resp.size() == 0) fail_now("resp_unexpected");
        else begin
          resp_t r;
          r = exp_resp.pop_front();
          chk("resp_aux_valid", aux_resp_valid, r.who);
          chk("resp_mem_valid", mem_resp_valid, !r.who);
          chk("resp_rdata", r.who ? aux_resp_rdata : mem_resp_rdata, r.rdata);
        end
      end
    end
  end

  task automatic push(input logic who, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata, input logic [3:0] wstrb,
                      input logic [31:0] rdata, input bit with_resp);
    exp_dc.push_back('{we: we, addr: addr, wdata: wdata, wstrb: wstrb});
    if (with_resp) exp_resp.push_back('{who: who, rdata: rdata});
  endtask

  task automatic issue_mem(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
    mem_req_valid = 1'b1; mem_req_we = we; mem_req_addr = addr;
    mem_req_wdata = wdata; mem_req_wstrb = wstrb;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_req_ready) begin
        @(posedge clk); #1;
        mem_req_valid = 1'b0;
        return;
      end
    end
    mem_req_valid = 1'b0;
    fail_now("mem_grant_timeout");
  endtask

  task automatic issue_aux(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb);
    aux_req_valid = 1'b1; aux_req_we = we; aux_req_addr = addr;
    aux_req_wdata = wdata; aux_req_wstrb = wstrb;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (aux_req_ready) begin
        @(posedge clk); #1;
        aux_req_valid = 1'b0;
        return;
      end
    end
    aux_req_valid = 1'b0;
    fail_now("aux_grant_timeout");
  endtask

  task automatic wait_drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 300 && !done; i++) begin
      @(negedge clk);
      if (exp_resp.size() == 0 && exp_dc.size() == 0 && !busy) done = 1'b1;
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s: got %0d/%0d pending expected 0", name, exp_dc.size(), exp_resp.size());
      exp_dc.delete();
      exp_resp.delete();
    end
    repeat (3) @(negedge clk);  // room for any stray pulse to be caught
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    chk("rst_dc_req_valid", dc_req_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_mem_resp_valid", mem_resp_valid, 0);
    chk("rst_aux_resp_valid", aux_resp_valid, 0);
    chk("rst_dc_addr", dc_addr, 0);
    chk("rst_mem_rdata", mem_resp_rdata, 0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    // Mem load only.
    push(0, 0, 32'h1000, 0, 0, 32'hDEAD_BEEF, 1);
    issue_mem(0, 32'h1000, 0, 4'h0);
    wait_drain("drain_mem_load");

    // Simultaneous mem store + aux load: mem first.
    push(0, 1, 32'h2000, 32'h1122_3344, 4'hF, 32'hCAFE_F00D, 1);
    push(1, 0, 32'h1004, 0, 0, 32'h1234_467C, 1);
    fork
      issue_mem(1, 32'h2000, 32'h1122_3344, 4'hF);
      issue_aux(0, 32'h1004, 0, 4'h0);
    join
    wait_drain("drain_simul");

    // Starvation: 8 mem grants, then aux, then the 9th mem.
    for (int i = 0; i < 8; i++) push(0, 0, 32'h4000 + 32'(4 * i), 0, 0,
                                     (32'h4000 + 32'(4 * i)) ^ 32'h1234_5678, 1);
    push(1, 0, 32'h5000, 0, 0, 32'h1234_0678, 1);
    push(0, 0, 32'h4020, 0, 0, 32'h1234_1658, 1);
    fork
      for (int i = 0; i < 9; i++) issue_mem(0, 32'h4000 + 32'(4 * i), 0, 4'h0);
      issue_aux(0, 32'h5000, 0, 4'h0);
    join
    wait_drain("drain_starve");

    // Flush in IDLE blocks the mem grant for that cycle.
    mem_req_valid = 1'b1; mem_req_we = 1'b0; mem_req_addr = 32'h6000; flush = 1'b1;
    @(negedge clk);
    chk("flush_idle_mem_ready", mem_req_ready, 0);
    chk("flush_idle_busy", busy, 0);
    @(posedge clk); #1;
    flush = 1'b0;
    push(0, 0, 32'h6000, 0, 0, 32'h1234_3678, 1);
    issue_mem(0, 32'h6000, 0, 4'h0);
    wait_drain("drain_flush_idle");

    // Flush during WAIT of a mem load: response squashed, aux then served.
    resp_delay = 3;
    push(0, 0, 32'h2000, 0, 0, 0, 0);
    issue_mem(0, 32'h2000, 0, 4'h0);
    @(posedge clk); #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    push(1, 0, 32'h1008, 0, 0, 32'h1234_4670, 1);
    issue_aux(0, 32'h1008, 0, 4'h0);
    wait_drain("drain_flush_wait");
    chk("dropped_load_rdata", mem_resp_rdata, 32'hCAFE_F00D);
    resp_delay = 1;

    // dcache stalls for 5 cycles in REQ.
    dc_req_ready = 1'b0;
    push(1, 1, 32'h3000, 32'hA5A5_A5A5, 4'b0011, 32'h1234_6678, 1);
    push(0, 0, 32'h1000, 0, 0, 32'hDEAD_BEEF, 1);
    issue_aux(1, 32'h3000, 32'hA5A5_A5A5, 4'b0011);
    fork
      issue_mem(0, 32'h1000, 0, 4'h0);
    join_none
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_dc_req_valid", dc_req_valid, 1);
      chk("stall_dc_addr", dc_addr, 32'h3000);
      chk("stall_dc_wdata", dc_wdata, 32'hA5A5_A5A5);
      chk("stall_dc_wstrb", dc_wstrb, 4'b0011);
      chk("stall_mem_ready", mem_req_ready, 0);
      chk("stall_aux_ready", aux_req_ready, 0);
      chk("stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    dc_req_ready = 1'b1;
    wait fork;
    wait_drain("drain_stall");

    // Async reset in WAIT; the late dcache response must not produce a pulse.
    resp_delay = 4;
    push(0, 0, 32'h1000, 0, 0, 0, 0);
    issue_mem(0, 32'h1000, 0, 4'h0);
    @(posedge clk);
    @(negedge clk);
    chk("wait_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_dc_req_valid", dc_req_valid, 0);
    chk("arst_busy", busy, 0);
    chk("arst_mem_resp_valid", mem_resp_valid, 0);
    chk("arst_aux_resp_valid", aux_resp_valid, 0);
    chk("arst_dc_addr", dc_addr, 0);
    chk("arst_mem_rdata", mem_resp_rdata, 0);
    chk("arst_aux_rdata", aux_resp_rdata, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    chk("stale_resp_mem_rdata", mem_resp_rdata, 0);
    chk("stale_resp_busy", busy, 0);
    @(posedge clk); #1;
    resp_delay = 1;

    // Normal service after reset.
    push(1, 0, 32'h2000, 0, 0, 32'hCAFE_F00D, 1);
    issue_aux(0, 32'h2000, 0, 4'h0);
    wait_drain("drain_post_reset");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
